// File: rtl/regfile_wr_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_demux_pkg
// Purpose  : Shared MIPS register-file widths and named register constants.
// Revision : 1.0
// ============================================================================
package regfile_wr_demux_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;
    localparam int MIPS_NREGS  = 32;

    // Shared with the destination mux and the control unit
    localparam logic [MIPS_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [MIPS_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage
`default_nettype wire

// File: rtl/regfile_wr_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_demux_if
// Purpose  : Writeback/decode-side bus of the register file.
// Revision : 1.0
// ============================================================================
interface regfile_wr_demux_if
    import regfile_wr_demux_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W,
    parameter int NREGS  = MIPS_NREGS
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [NREGS-1:0]  wr_onehot;
    logic [ADDR_W-1:0] last_wr_addr;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_onehot, last_wr_addr
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_onehot, last_wr_addr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_demux_decoder5to32.sv
`default_nettype none
// ============================================================================
// Module   : decoder5to32
// Purpose  : Combinational enable-gated address-to-one-hot demultiplexer.
// Revision : 1.0
// ============================================================================
module decoder5to32
    import regfile_wr_demux_pkg::*;
#(
    parameter int ADDR_W = MIPS_ADDR_W,
    parameter int NREGS  = MIPS_NREGS
) (
    input  wire logic              en,
    input  wire logic [ADDR_W-1:0] addr,
    output logic      [NREGS-1:0]  onehot
);
    always_comb begin
        onehot       = '0;
        onehot[addr] = en;
    end
endmodule
`default_nettype wire

// File: rtl/regfile_wr_demux.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_demux
// Purpose  : 32x32 register file with one-hot write decode, bypassed reads
//            and registered commit status.
// Revision : 1.0
// ============================================================================
module regfile_wr_demux
    import regfile_wr_demux_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W,
    parameter int NREGS  = MIPS_NREGS
) (
    input wire logic          clk,
    input wire logic          rst_n,
    regfile_wr_demux_if.slave bus
);
    localparam logic [NREGS-1:0] C_ZERO_BIT = NREGS'(1);

    logic [NREGS-1:0]  w_onehot;
    logic [NREGS-1:0]  w_dec;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_wr_onehot;
    logic [ADDR_W-1:0] r_last_wr_addr;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    decoder5to32 #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_dec (
        .en     (bus.wr_en),
        .addr   (bus.wr_addr),
        .onehot (w_onehot)
    );

    // $zero can never be a write target
    assign w_dec = w_onehot & ~C_ZERO_BIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_dec[i]) begin
                    r_regs[i] <= bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_onehot    <= '0;
            r_last_wr_addr <= '0;
        end else if (|w_dec) begin
            r_wr_onehot    <= w_dec;
            r_last_wr_addr <= bus.wr_addr;
        end else begin
            r_wr_onehot    <= '0;
        end
    end

    // Reads stay at zero while in reset so a pending write cannot leak through
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if (rst_n && bus.rd_addr_a != REG_ZERO) begin
            if (bus.wr_en && bus.wr_addr == bus.rd_addr_a) w_rd_a = bus.wr_data;
            else                                          w_rd_a = r_regs[bus.rd_addr_a];
        end
        if (rst_n && bus.rd_addr_b != REG_ZERO) begin
            if (bus.wr_en && bus.wr_addr == bus.rd_addr_b) w_rd_b = bus.wr_data;
            else                                          w_rd_b = r_regs[bus.rd_addr_b];
        end
    end

    assign bus.rd_data_a    = w_rd_a;
    assign bus.rd_data_b    = w_rd_b;
    assign bus.wr_onehot    = r_wr_onehot;
    assign bus.last_wr_addr = r_last_wr_addr;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_demux
// Purpose  : Directed and random checks of regfile_wr_demux against a model.
// Revision : 1.0
// ============================================================================
module tb_regfile_wr_demux;
    logic clk;
    logic rst_n;

    regfile_wr_demux_if bus ();

    regfile_wr_demux u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total;
    int unsigned passed;

    logic [31:0] model [32];
    logic [31:0] exp_onehot;
    logic [4:0]  exp_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0)                       return 32'h0;
        if (bus.wr_en && bus.wr_addr == a)             return bus.wr_data;
        return model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        exp_onehot = 32'h0;
        exp_last   = 5'd0;
    endtask

    // One clock edge: apply the commit rules to the model, then settle past the edge
    task automatic edge_step();
        if (rst_n) begin
            if (bus.wr_en && bus.wr_addr != 5'd0) begin
                model[bus.wr_addr] = bus.wr_data;
                exp_onehot         = 32'h1 << bus.wr_addr;
                exp_last           = bus.wr_addr;
            end else begin
                exp_onehot = 32'h0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_rda"}, bus.rd_data_a, exp_read(bus.rd_addr_a));
        check({tag, "_rdb"}, bus.rd_data_b, exp_read(bus.rd_addr_b));
    endtask

    task automatic check_status(input string tag);
        check({tag, "_onehot"}, bus.wr_onehot, exp_onehot);
        check({tag, "_last"}, 32'(bus.last_wr_addr), 32'(exp_last));
    endtask

    initial begin
        total  = 0;
        passed = 0;
        model_reset();

        // Reset held with a pending write to r5
        rst_n         = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd5;
        bus.wr_data   = 32'hDEADBEEF;
        bus.rd_addr_a = 5'd5;
        bus.rd_addr_b = 5'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_rda", bus.rd_data_a, 32'h0);
        check("rst_onehot", bus.wr_onehot, 32'h0);
        check("rst_last", 32'(bus.last_wr_addr), 32'h0);

        rst_n = 1'b1;
        edge_step();
        check("rel_rda", bus.rd_data_a, 32'hDEADBEEF);
        check("rel_onehot", bus.wr_onehot, 32'h00000020);
        check("rel_last", 32'(bus.last_wr_addr), 32'd5);
        bus.wr_en = 1'b0;
        #1 check("rel_rda_array", bus.rd_data_a, 32'hDEADBEEF);

        // Write to $zero
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
        bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0;
        #1 check_reads("zero_comb");
        check("zero_comb_a0", bus.rd_data_a, 32'h0);
        edge_step();
        check("zero_next_a", bus.rd_data_a, 32'h0);
        check("zero_next_b", bus.rd_data_b, 32'h0);
        check("zero_onehot", bus.wr_onehot, 32'h0);
        check("zero_last", 32'(bus.last_wr_addr), 32'd5);

        // Bypass over an older value in r7
        bus.wr_addr = 5'd7; bus.wr_data = 32'h11111111;
        edge_step();
        bus.wr_data = 32'h22222222; bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd7;
        #1 check("byp_comb_a", bus.rd_data_a, 32'h22222222);
        check("byp_comb_b", bus.rd_data_b, 32'h22222222);
        edge_step();
        bus.wr_en = 1'b0;
        #1 check("byp_after_a", bus.rd_data_a, 32'h22222222);
        check("byp_after_b", bus.rd_data_b, 32'h22222222);

        // Sweep writes over r1..r31
        bus.wr_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.wr_addr = 5'(i);
            bus.wr_data = 32'(i) * 32'h01010101;
            edge_step();
            check("sweep_onehot", bus.wr_onehot, 32'h1 << i);
            check("sweep_last", 32'(bus.last_wr_addr), 32'(i));
        end

        // Idle edge after the r31 write
        bus.wr_en = 1'b0;
        edge_step();
        check("idle_onehot", bus.wr_onehot, 32'h0);
        check("idle_last", 32'(bus.last_wr_addr), 32'd31);
        for (int i = 1; i < 32; i++) begin
            bus.rd_addr_a = 5'(i);
            bus.rd_addr_b = 5'(32 - i);
            #1;
            check("sweep_rda", bus.rd_data_a, 32'(i) * 32'h01010101);
            check("sweep_rdb", bus.rd_data_b, 32'(32 - i) * 32'h01010101);
        end

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_addr   = 5'($urandom);
            bus.wr_data   = $urandom;
            bus.rd_addr_a = 5'($urandom);
            bus.rd_addr_b = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 5'($urandom);
            #1 check_reads("rnd");
            edge_step();
            check_status("rnd");
        end

        // Asynchronous reset between edges after an r3 write
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5A5A5A5;
        edge_step();
        bus.wr_en = 1'b0; bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd3;
        #1 check("mid_pre_rda", bus.rd_data_a, 32'hA5A5A5A5);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("mid_rst_rda", bus.rd_data_a, 32'h0);
        check_status("mid_rst");
        bus.wr_en = 1'b1; bus.wr_data = 32'h12345678;
        #1 check("mid_rst_nobyp", bus.rd_data_b, 32'h0);
        edge_step();
        rst_n = 1'b1; bus.wr_en = 1'b0;
        #1 check("post_rst_r3", bus.rd_data_a, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
